// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: single-cycle request / registered response peripheral bus used by uart_tx_fifo.
interface uart_tx_fifo_if;
    logic        mem_valid;
    logic        mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_error;
    modport master (output mem_valid, mem_addr, mem_wstrb, mem_wdata, input mem_rdata, mem_ready, mem_error);
    modport slave (input mem_valid, mem_addr, mem_wstrb, mem_wdata, output mem_rdata, mem_ready, mem_error);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter behind a DATA/STATUS register pair.
// Define UART_TX_PARITY_EN to insert a parity bit between the data bits and the stop bits.
module uart_tx_fifo #(
    parameter int CLOCK_DIV  = 868,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          clock,
    input  logic          reset,
    uart_tx_fifo_if.slave bus,
    output logic          tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLOCK_DIV);
    localparam int BW = $clog2(DATA_BITS);
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam state_t POST_DATA = PARITY;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam state_t POST_DATA = STOP;
`endif
    state_t state, state_d;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] shift, head;
    logic [AW:0] wptr, rptr, count;
    logic [CW-1:0] baud_cnt;
    logic [BW-1:0] bit_idx;
    logic [31:0] status;
    logic parity_odd, empty, full, wr, push, pop, bit_end, last_data, last_stop, tx_d;
    logic unused_wdata;
`ifdef UART_TX_PARITY_EN
    logic par;
`endif
    assign empty = wptr == rptr;
    assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = wptr - rptr;
    assign head = mem[rptr[AW-1:0]];
    assign wr = |bus.mem_wstrb;
    assign push = bus.mem_valid && wr && !bus.mem_addr && !full;
    assign bit_end = baud_cnt == CW'(CLOCK_DIV - 1);
    assign last_data = bit_end && bit_idx == BW'(DATA_BITS - 1);
    assign last_stop = bit_end && bit_idx == BW'(STOP_BITS - 1);
    assign status = {16'h0, 8'(count), 4'h0, parity_odd, state != IDLE, full, empty};
    assign unused_wdata = ^bus.mem_wdata[31:DATA_BITS];
    // tx is registered from the current state, so the line trails the FSM by one cycle
    always_comb begin
        state_d = state;
        pop = 1'b0;
        tx_d = 1'b1;
        case (state)
            IDLE: begin
                pop = !empty;
                state_d = empty ? IDLE : START;
            end
            START: begin
                tx_d = 1'b0;
                state_d = bit_end ? DATA : START;
            end
            DATA: begin
                tx_d = shift[0];
                state_d = last_data ? POST_DATA : DATA;
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_d = par ^ parity_odd;
                state_d = bit_end ? STOP : PARITY;
            end
`endif
            STOP: begin
                pop = last_stop && !empty;
                state_d = !last_stop ? STOP : empty ? IDLE : START;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (push) mem[wptr[AW-1:0]] <= bus.mem_wdata[DATA_BITS-1:0];
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            wptr <= '0;
            rptr <= '0;
            baud_cnt <= '0;
            bit_idx <= '0;
            shift <= '0;
            tx <= 1'b1;
            parity_odd <= 1'b0;
            bus.mem_ready <= 1'b0;
            bus.mem_error <= 1'b0;
            bus.mem_rdata <= '0;
        end else begin
            state <= state_d;
            wptr <= wptr + (AW + 1)'(push);
            rptr <= rptr + (AW + 1)'(pop);
            baud_cnt <= (state == IDLE || bit_end) ? '0 : baud_cnt + CW'(1);
            bit_idx <= (state_d != state) ? '0 : bit_idx + BW'(bit_end);
            shift <= pop ? head : (state == DATA && bit_end) ? shift >> 1 : shift;
            tx <= tx_d;
            if (bus.mem_valid && bus.mem_addr && wr) parity_odd <= bus.mem_wdata[0];
            bus.mem_ready <= bus.mem_valid;
            bus.mem_error <= bus.mem_valid && !bus.mem_addr && (!wr || full);
            bus.mem_rdata <= (bus.mem_valid && bus.mem_addr && !wr) ? status : '0;
        end
    end
`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clock) begin
        if (reset) par <= 1'b0;
        else if (pop) par <= ^head;
    end
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and random bus traffic checked against a frame-timeline model.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int DIV = 4;
    localparam int DB = 8;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int L = (2 + DB + PB) * DIV;
    typedef struct {
        int push;
        int start;
        logic [DB-1:0] data;
    } frame_t;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic tx, tx2;
    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    frame_t fq[$];
    int last_start = -1000;
    logic par_mode = 1'b0;
    logic exp_tx = 1'b1;
    logic exp_ready = 1'b0;
    logic exp_err = 1'b0;
    logic [31:0] exp_rdata = '0;
    uart_tx_fifo_if bus ();
    uart_tx_fifo_if bus2 ();
    uart_tx_fifo #(.CLOCK_DIV(DIV), .DATA_BITS(DB), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .bus(bus), .tx(tx));
    uart_tx_fifo #(.CLOCK_DIV(4), .DATA_BITS(5), .STOP_BITS(2), .FIFO_DEPTH(2)) dut2 (
        .clock(clock), .reset(reset), .bus(bus2), .tx(tx2));
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // words sitting in the FIFO during the cycle before edge m
    function automatic int occ(input int m);
        int k = 0;
        foreach (fq[i]) if (fq[i].push < m && fq[i].start > m) k++;
        return k;
    endfunction

    function automatic logic busy_at(input int m);
        foreach (fq[i]) if (fq[i].start <= m && m < fq[i].start + L) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic fbit(input logic [DB-1:0] d, input int b, input logic pm);
        if (b == 0) return 1'b0;
        if (b <= DB) return d[b-1];
        if (PB == 1 && b == DB + 1) return ^d ^ pm;
        return 1'b1;
    endfunction

    // a frame occupies the line for L cycles starting two edges after acceptance, or straight after its predecessor
    always @(posedge clock) begin : model
        int n;
        cyc++;
        exp_tx = 1'b1;
        foreach (fq[i])
            if (!reset && fq[i].start <= cyc && cyc < fq[i].start + L)
                exp_tx = fbit(fq[i].data, (cyc - fq[i].start) / DIV, par_mode);
        exp_ready = !reset && bus.mem_valid;
        exp_err = 1'b0;
        exp_rdata = '0;
        n = occ(cyc);
        if (reset) begin
            fq.delete();
            last_start = -1000;
            par_mode = 1'b0;
        end else if (bus.mem_valid && !bus.mem_addr) begin
            if (bus.mem_wstrb == 4'h0 || n == DEPTH) exp_err = 1'b1;
            else begin
                last_start = (cyc + 2 > last_start + L) ? cyc + 2 : last_start + L;
                fq.push_back('{push: cyc, start: last_start, data: bus.mem_wdata[DB-1:0]});
            end
        end else if (bus.mem_valid && bus.mem_wstrb != 4'h0) par_mode = bus.mem_wdata[0];
        else if (bus.mem_valid) exp_rdata = {16'h0, 8'(n), 4'h0, par_mode, busy_at(cyc), n == DEPTH, n == 0};
        while (fq.size() > 0 && fq[0].start + L < cyc) void'(fq.pop_front());
    end

    always @(negedge clock) begin
        if (cyc > 0) begin
            check("tx", tx, exp_tx);
            check("ready", bus.mem_ready, exp_ready);
            if (exp_ready) begin
                check("error", bus.mem_error, exp_err);
                check("rdata", bus.mem_rdata, exp_rdata);
            end
        end
    end

    task automatic req(input logic a, input logic [3:0] s, input logic [31:0] d, output int en);
        bus.mem_valid = 1'b1;
        bus.mem_addr = a;
        bus.mem_wstrb = s;
        bus.mem_wdata = d;
        en = cyc + 1;
        @(negedge clock);
        bus.mem_valid = 1'b0;
    endtask

    task automatic wait_edge(input int e);
        while (cyc < e) @(negedge clock);
    endtask

    initial begin
        int n;
        logic [10:0] pat;
        bus.mem_valid = 1'b0;
        bus.mem_addr = 1'b0;
        bus.mem_wstrb = 4'h0;
        bus.mem_wdata = '0;
        bus2.mem_valid = 1'b0;
        bus2.mem_addr = 1'b0;
        bus2.mem_wstrb = 4'h0;
        bus2.mem_wdata = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("idle_tx", tx, 1'b1);
        req(1'b1, 4'h0, '0, n);
        check("idle_ready", bus.mem_ready, 1'b1);
        check("idle_status", bus.mem_rdata, 32'h0000_0001);
        req(1'b0, 4'h1, 32'h55, n);
        check("w55_err", bus.mem_error, 1'b0);
        wait_edge(n + 1);
        check("w55_lat", tx, 1'b1);
`ifdef UART_TX_PARITY_EN
        pat = 11'b10010101010;
`else
        pat = 11'b11010101010;
`endif
        for (int i = 0; i < 44; i++) begin
            wait_edge(n + 2 + i);
            check("w55_tx", tx, pat[i / DIV]);
        end
        req(1'b0, 4'hF, 32'hA1, n);
        wait_edge(n + 2);
        for (int i = 0; i < 5; i++) begin
            req(1'b0, 4'h3, 32'hB0 + i, n);
            check("fill_err", bus.mem_error, i == 4);
        end
        req(1'b1, 4'h0, '0, n);
        check("full_status", bus.mem_rdata, 32'h0000_0406);
        wait_edge(cyc + 5 * L + 8);
        req(1'b1, 4'h0, '0, n);
        check("drained_status", bus.mem_rdata, 32'h0000_0001);
`ifdef UART_TX_PARITY_EN
        req(1'b0, 4'hF, 32'h07, n);
        wait_edge(n + 2 + 9 * DIV + 1);
        check("par_even", tx, 1'b1);
        wait_edge(n + 2 + L);
        req(1'b1, 4'hF, 32'h1, n);
        req(1'b0, 4'hF, 32'h07, n);
        wait_edge(n + 2 + 9 * DIV + 1);
        check("par_odd", tx, 1'b0);
        wait_edge(n + 2 + L);
        req(1'b1, 4'hF, 32'h0, n);
`endif
        req(1'b0, 4'hF, 32'h5A, n);
        wait_edge(n + 2 + 3 * DIV);
        check("pre_rst_tx", tx, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        check("rst_tx", tx, 1'b1);
        reset = 1'b0;
        @(negedge clock);
        req(1'b1, 4'h0, '0, n);
        check("rst_status", bus.mem_rdata, 32'h0000_0001);
        bus2.mem_valid = 1'b1;
        bus2.mem_addr = 1'b0;
        bus2.mem_wstrb = 4'hF;
        bus2.mem_wdata = 32'h1F;
        n = cyc + 1;
        @(negedge clock);
        bus2.mem_valid = 1'b0;
        check("d2_err", bus2.mem_error, 1'b0);
        for (int i = 0; i < 40; i++) begin
            wait_edge(n + 2 + i);
            check("d2_tx", tx2, i >= 4);
            if (bus2.mem_valid) begin
                bus2.mem_valid = 1'b0;
                check("d2_status", bus2.mem_rdata, (cyc == n + 33 || PB == 1) ? 32'h5 : 32'h1);
            end
            if (cyc + 1 == n + 33 || cyc + 1 == n + 34) begin
                bus2.mem_valid = 1'b1;
                bus2.mem_addr = 1'b1;
                bus2.mem_wstrb = 4'h0;
            end
        end
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(2) == 0) begin
                bus.mem_valid = 1'b1;
                bus.mem_addr = ($urandom_range(3) == 0);
                bus.mem_wstrb = ($urandom_range(4) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
                bus.mem_wdata = $urandom;
            end else bus.mem_valid = 1'b0;
            @(negedge clock);
        end
        bus.mem_valid = 1'b0;
        wait_edge(cyc + (DEPTH + 2) * L);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
